stage_wb: RTL and testbench
===========================

Name: stage_wb

Overview:
- In-order per-thread commit/writeback stage; consumes the TLWB bundle produced by stage_tl.
- Replaces the ad-hoc commit logic in the top level.
- Owns per-thread waiting_pc, exception state and the rm0/rm1/rm2/rm4 registers.
- Drives the register-file write port, PC redirects, the ID invalidate request, store issue, TLB writes and the exception handshake toward IF.

Parameters:
- N_THREADS, 8, number of hardware threads (threadid_t width = clog2).
- RESET_PC, 32'h1000, per-thread waiting_pc/redirect value after reset.
- EXC_VECTOR, 32'h2000, handler entry PC on TLB miss.
- END_PC, 32'hFFFFFFFF, PC whose commit marks a thread finished.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- tl_thread  in  clog2(N_THREADS)  thread of incoming instruction.
- tl_isvalid, tl_itlb_miss, tl_dtlb_miss  in  1 each  validity and miss flags.
- tl_pc  in  32  instruction PC.
- tl_dst  in  5  destination register.
- tl_data  in  32  ALU/load result, or address for store/tlbwrite/jump.
- tl_mul  in  32  multiplier result.
- tl_r2  in  32  store data, or PPN source.
- tl_isequal  in  1  branch compare result.
- tl_flag_mul, tl_flag_reg, tl_flag_jump, tl_flag_branch, tl_flag_iret, tl_flag_store, tl_flag_isbyte  in  1 each.
- tl_flag_tlbwrite  in  tlbwrite_t  none/itlb/dtlb.
- rf_wen  out  1  register-file write enable.
- rf_thread  out  clog2(N_THREADS)  write thread.
- rf_dst  out  5  write register.
- rf_data  out  32  write data.
- redirect_en  out  1  PC redirect pulse.
- redirect_thread  out  clog2(N_THREADS)  redirected thread.
- redirect_pc  out  32  redirect target.
- invalidate_en  out  1  pulse: ID discards the thread's in-flight history.
- invalidate_thread  out  clog2(N_THREADS)  thread to invalidate.
- store_en  out  1  store issue pulse.
- store_isbyte  out  1  byte store.
- store_addr  out  20  tl_data[19:0].
- store_data  out  32  tl_r2.
- itlb_wen, dtlb_wen  out  1 each  TLB write pulses.
- tlbwrite_vpn  out  20  tl_data[19:0].
- tlbwrite_ppn  out  8  tl_r2[7:0].
- exc_en  out  1  exception-entry pulse.
- exc_thread  out  clog2(N_THREADS)  faulting thread.
- mode  out  N_THREADS  rm4[i][0] per thread; 1 = supervisor.
- done  out  1  every thread's waiting_pc == END_PC.

Behaviour:
- All outputs registered; effects appear exactly 1 cycle after the TLWB input cycle.
- Pulse outputs (rf_wen, redirect_en, invalidate_en, store_en, itlb_wen, dtlb_wen, exc_en) default to 0 every cycle.
- Reset, synchronous, takes priority over all else:
  - waiting_pc[i] = RESET_PC; rm0, rm1, rm2 = 0; rm4 = 1.
  - Exception state cleared (exc_active = 0, master = 0).
  - All pulse outputs 0; done = 0; data outputs 0.
- Head check: the instruction is at head iff tl_pc == waiting_pc[tl_thread]. Non-head input is dropped silently, with no outputs.
- Fence: fence_ok = !exc_active || tl_thread == master.
- Head with (!tl_isvalid || !fence_ok), retry:
  - redirect_en = 1, redirect_pc = waiting_pc[t].
  - invalidate_en = 1 for t.
  - No architectural update.
- Head, valid, fence_ok, (itlb_miss || dtlb_miss), exception entry:
  - If exc_active is already set, the instruction is retried instead.
  - Otherwise: exc_active = 1, master = t.
  - rm0 = tl_pc; rm1 = dtlb_miss ? tl_data : tl_pc; rm2 = {30'b0, dtlb_miss, itlb_miss}; rm4 = 1.
  - waiting_pc = EXC_VECTOR; redirect to EXC_VECTOR; invalidate t; exc_en = 1, exc_thread = t.
  - No regfile, store or TLB effect.
- Head, valid, fence_ok, no miss, commit:
  - Default: waiting_pc += 4.
  - If flag_reg: rf_wen = 1, rf_data = flag_mul ? tl_mul : tl_data. Writes with dst == 0 are suppressed.
  - Taken jump (jump && (!branch || isequal)): waiting_pc = tl_data; redirect to tl_data; invalidate t.
  - flag_store: store_en = 1.
  - tlbwrite itlb or dtlb: pulse the matching wen.
  - iret: waiting_pc = rm0[t]; redirect to rm0[t]; invalidate t; rm4[t] = 0. Clear exc_active if t == master.
  - Priority: iret over jump, jump over default +4.
- waiting_pc arithmetic is 32-bit and wraps at 2^32 with no trap.
- done is registered, recomputed every cycle, and is sticky only through waiting_pc.

Test Plan:
- Reset, then t0 head pc=0x1000, valid, reg, dst=3, data=0x55 -> next cycle rf_wen=1, rf_dst=3, rf_data=0x55; waiting_pc[0]=0x1004.
- t2 pc=0x1008 while waiting_pc[2]=0x1000 -> no output pulses; waiting_pc unchanged.
- t1 head valid, dtlb_miss, data=0xABCDE -> exc_en=1, exc_thread=1, redirect_pc=0x2000, rm1=0xABCDE, mode[1]=1; then t4 head valid -> retry with redirect_pc=waiting_pc[4] and invalidate_en=1.
- Master t1 commits iret (rm0=0x1010) -> redirect_pc=0x1010, mode[1]=0, exc_active cleared; t4 then commits normally.
- Branch with isequal=0, then isequal=1 with data=0x1400 -> first gives +4 and no redirect; second gives redirect_pc=0x1400 and invalidate_en=1.
- Store isbyte with data=0x12345678, r2=0xFF -> store_en=1, store_addr=0x45678, store_data=0xFF, store_isbyte=1; tlbwrite dtlb -> dtlb_wen=1, vpn=0x45678, ppn=0xFF.

Source files
------------

// File: rtl/stage_wb.sv
// rtl/stage_wb.sv - in-order per-thread commit/writeback stage fed by stage_tl
// Owns waiting_pc, the exception fence and rm0/rm1/rm2/rm4; every output is registered.
package stage_wb_pkg;
  typedef enum logic [1:0] {
    TLBW_NONE = 2'd0,
    TLBW_ITLB = 2'd1,
    TLBW_DTLB = 2'd2
  } tlbwrite_t;
endpackage

module stage_wb
  import stage_wb_pkg::*;
#(
  parameter int          N_THREADS  = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_1000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_2000,
  parameter logic [31:0] END_PC     = 32'hFFFF_FFFF,
  localparam int         TW         = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TW-1:0]               tl_thread,
  input  logic                        tl_isvalid,
  input  logic                        tl_itlb_miss,
  input  logic                        tl_dtlb_miss,
  input  logic [31:0]                 tl_pc,
  input  logic [4:0]                  tl_dst,
  input  logic [31:0]                 tl_data,
  input  logic [31:0]                 tl_mul,
  input  logic [31:0]                 tl_r2,
  input  logic                        tl_isequal,
  input  logic                        tl_flag_mul,
  input  logic                        tl_flag_reg,
  input  logic                        tl_flag_jump,
  input  logic                        tl_flag_branch,
  input  logic                        tl_flag_iret,
  input  logic                        tl_flag_store,
  input  logic                        tl_flag_isbyte,
  input  tlbwrite_t                   tl_flag_tlbwrite,
  output logic                        rf_wen,
  output logic [TW-1:0]               rf_thread,
  output logic [4:0]                  rf_dst,
  output logic [31:0]                 rf_data,
  output logic                        redirect_en,
  output logic [TW-1:0]               redirect_thread,
  output logic [31:0]                 redirect_pc,
  output logic                        invalidate_en,
  output logic [TW-1:0]               invalidate_thread,
  output logic                        store_en,
  output logic                        store_isbyte,
  output logic [19:0]                 store_addr,
  output logic [31:0]                 store_data,
  output logic                        itlb_wen,
  output logic                        dtlb_wen,
  output logic [19:0]                 tlbwrite_vpn,
  output logic [7:0]                  tlbwrite_ppn,
  output logic                        exc_en,
  output logic [TW-1:0]               exc_thread,
  output logic [N_THREADS-1:0]        mode,
  output logic                        done,
  output logic [N_THREADS-1:0][31:0]  dbg_rm1,
  output logic [N_THREADS-1:0][31:0]  dbg_rm2
);

  typedef struct packed {
    logic            rf_wen;
    logic [TW-1:0]   rf_thread;
    logic [4:0]      rf_dst;
    logic [31:0]     rf_data;
    logic            redirect_en;
    logic [TW-1:0]   redirect_thread;
    logic [31:0]     redirect_pc;
    logic            invalidate_en;
    logic [TW-1:0]   invalidate_thread;
    logic            store_en;
    logic            store_isbyte;
    logic [19:0]     store_addr;
    logic [31:0]     store_data;
    logic            itlb_wen;
    logic            dtlb_wen;
    logic [19:0]     tlbwrite_vpn;
    logic [7:0]      tlbwrite_ppn;
    logic            exc_en;
    logic [TW-1:0]   exc_thread;
    logic            done;
  } out_t;

  out_t                  out_d, out_q;
  logic [31:0]           wpc_q [N_THREADS];
  logic [31:0]           wpc_d [N_THREADS];
  logic [31:0]           rm0_q [N_THREADS];
  logic [31:0]           rm0_d [N_THREADS];
  logic [31:0]           rm1_q [N_THREADS];
  logic [31:0]           rm1_d [N_THREADS];
  logic [1:0]            rm2_q [N_THREADS];
  logic [1:0]            rm2_d [N_THREADS];
  logic [N_THREADS-1:0]  rm4_q, rm4_d;
  logic                  exc_active_q, exc_active_d;
  logic [TW-1:0]         master_q, master_d;
  logic                  head, fence_ok, miss, taken, all_end;

  always_comb begin
    wpc_d        = wpc_q;
    rm0_d        = rm0_q;
    rm1_d        = rm1_q;
    rm2_d        = rm2_q;
    rm4_d        = rm4_q;
    exc_active_d = exc_active_q;
    master_d     = master_q;
    out_d               = out_q;
    out_d.rf_wen        = 1'b0;
    out_d.redirect_en   = 1'b0;
    out_d.invalidate_en = 1'b0;
    out_d.store_en      = 1'b0;
    out_d.itlb_wen      = 1'b0;
    out_d.dtlb_wen      = 1'b0;
    out_d.exc_en        = 1'b0;

    head     = (tl_pc == wpc_q[tl_thread]);
    fence_ok = !exc_active_q || (tl_thread == master_q);
    miss     = tl_itlb_miss || tl_dtlb_miss;
    taken    = tl_flag_jump && (!tl_flag_branch || tl_isequal);

    if (head) begin
      // A second miss while a handler is running is replayed, never nested.
      if (!tl_isvalid || !fence_ok || (miss && exc_active_q)) begin
        out_d.redirect_en       = 1'b1;
        out_d.redirect_thread   = tl_thread;
        out_d.redirect_pc       = wpc_q[tl_thread];
        out_d.invalidate_en     = 1'b1;
        out_d.invalidate_thread = tl_thread;
      end else if (miss) begin
        exc_active_d            = 1'b1;
        master_d                = tl_thread;
        rm0_d[tl_thread]        = tl_pc;
        rm1_d[tl_thread]        = tl_dtlb_miss ? tl_data : tl_pc;
        rm2_d[tl_thread]        = {tl_dtlb_miss, tl_itlb_miss};
        rm4_d[tl_thread]        = 1'b1;
        wpc_d[tl_thread]        = EXC_VECTOR;
        out_d.redirect_en       = 1'b1;
        out_d.redirect_thread   = tl_thread;
        out_d.redirect_pc       = EXC_VECTOR;
        out_d.invalidate_en     = 1'b1;
        out_d.invalidate_thread = tl_thread;
        out_d.exc_en            = 1'b1;
        out_d.exc_thread        = tl_thread;
      end else begin
        wpc_d[tl_thread] = wpc_q[tl_thread] + 32'd4;
        if (tl_flag_reg && (tl_dst != 5'd0)) begin
          out_d.rf_wen    = 1'b1;
          out_d.rf_thread = tl_thread;
          out_d.rf_dst    = tl_dst;
          out_d.rf_data   = tl_flag_mul ? tl_mul : tl_data;
        end
        if (tl_flag_iret) begin
          wpc_d[tl_thread]        = rm0_q[tl_thread];
          rm4_d[tl_thread]        = 1'b0;
          out_d.redirect_en       = 1'b1;
          out_d.redirect_thread   = tl_thread;
          out_d.redirect_pc       = rm0_q[tl_thread];
          out_d.invalidate_en     = 1'b1;
          out_d.invalidate_thread = tl_thread;
          if (tl_thread == master_q) exc_active_d = 1'b0;
        end else if (taken) begin
          wpc_d[tl_thread]        = tl_data;
          out_d.redirect_en       = 1'b1;
          out_d.redirect_thread   = tl_thread;
          out_d.redirect_pc       = tl_data;
          out_d.invalidate_en     = 1'b1;
          out_d.invalidate_thread = tl_thread;
        end
        if (tl_flag_store) begin
          out_d.store_en     = 1'b1;
          out_d.store_isbyte = tl_flag_isbyte;
          out_d.store_addr   = tl_data[19:0];
          out_d.store_data   = tl_r2;
        end
        if (tl_flag_tlbwrite != TLBW_NONE) begin
          out_d.itlb_wen     = (tl_flag_tlbwrite == TLBW_ITLB);
          out_d.dtlb_wen     = (tl_flag_tlbwrite == TLBW_DTLB);
          out_d.tlbwrite_vpn = tl_data[19:0];
          out_d.tlbwrite_ppn = tl_r2[7:0];
        end
      end
    end

    all_end = 1'b1;
    for (int i = 0; i < N_THREADS; i++) begin
      if (wpc_d[i] != END_PC) all_end = 1'b0;
    end
    out_d.done = all_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_THREADS; i++) begin
        wpc_q[i] <= RESET_PC;
        rm0_q[i] <= '0;
        rm1_q[i] <= '0;
        rm2_q[i] <= '0;
      end
      rm4_q        <= '1;
      exc_active_q <= 1'b0;
      master_q     <= '0;
      out_q        <= '0;
    end else begin
      wpc_q        <= wpc_d;
      rm0_q        <= rm0_d;
      rm1_q        <= rm1_d;
      rm2_q        <= rm2_d;
      rm4_q        <= rm4_d;
      exc_active_q <= exc_active_d;
      master_q     <= master_d;
      out_q        <= out_d;
    end
  end

  assign rf_wen            = out_q.rf_wen;
  assign rf_thread         = out_q.rf_thread;
  assign rf_dst            = out_q.rf_dst;
  assign rf_data           = out_q.rf_data;
  assign redirect_en       = out_q.redirect_en;
  assign redirect_thread   = out_q.redirect_thread;
  assign redirect_pc       = out_q.redirect_pc;
  assign invalidate_en     = out_q.invalidate_en;
  assign invalidate_thread = out_q.invalidate_thread;
  assign store_en          = out_q.store_en;
  assign store_isbyte      = out_q.store_isbyte;
  assign store_addr        = out_q.store_addr;
  assign store_data        = out_q.store_data;
  assign itlb_wen          = out_q.itlb_wen;
  assign dtlb_wen          = out_q.dtlb_wen;
  assign tlbwrite_vpn      = out_q.tlbwrite_vpn;
  assign tlbwrite_ppn      = out_q.tlbwrite_ppn;
  assign exc_en            = out_q.exc_en;
  assign exc_thread        = out_q.exc_thread;
  assign done              = out_q.done;
  assign mode              = rm4_q;

  // Fault cause registers, visible to the handler's debug view.
  always_comb begin
    for (int i = 0; i < N_THREADS; i++) begin
      dbg_rm1[i] = rm1_q[i];
      dbg_rm2[i] = {30'b0, rm2_q[i]};
    end
  end

endmodule

// File: tb/tb_stage_wb.sv
// tb/tb_stage_wb.sv - self-checking bench for stage_wb
// Directed table, hand-written corner sequences and random traffic against a rule-level model.
module tb_stage_wb;
  import stage_wb_pkg::*;

  localparam int NT = 8;
  localparam logic [31:0] EXC_PC = 32'h0000_2000;
  localparam logic [31:0] END_PC = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] tl_thread;
  logic tl_isvalid, tl_itlb_miss, tl_dtlb_miss;
  logic [31:0] tl_pc, tl_data, tl_mul, tl_r2;
  logic [4:0] tl_dst;
  logic tl_isequal, tl_flag_mul, tl_flag_reg, tl_flag_jump, tl_flag_branch;
  logic tl_flag_iret, tl_flag_store, tl_flag_isbyte;
  tlbwrite_t tl_flag_tlbwrite;
  logic rf_wen, redirect_en, invalidate_en, store_en, store_isbyte;
  logic itlb_wen, dtlb_wen, exc_en, done;
  logic [2:0] rf_thread, redirect_thread, invalidate_thread, exc_thread;
  logic [4:0] rf_dst;
  logic [31:0] rf_data, redirect_pc, store_data;
  logic [19:0] store_addr, tlbwrite_vpn;
  logic [7:0] tlbwrite_ppn;
  logic [NT-1:0] mode;
  logic [NT-1:0][31:0] dbg_rm1, dbg_rm2;

  always #5 clk = ~clk;

  stage_wb #(.N_THREADS(NT)) dut (
    .clk(clk), .rst(rst),
    .tl_thread(tl_thread), .tl_isvalid(tl_isvalid),
    .tl_itlb_miss(tl_itlb_miss), .tl_dtlb_miss(tl_dtlb_miss),
    .tl_pc(tl_pc), .tl_dst(tl_dst), .tl_data(tl_data), .tl_mul(tl_mul), .tl_r2(tl_r2),
    .tl_isequal(tl_isequal), .tl_flag_mul(tl_flag_mul), .tl_flag_reg(tl_flag_reg),
    .tl_flag_jump(tl_flag_jump), .tl_flag_branch(tl_flag_branch), .tl_flag_iret(tl_flag_iret),
    .tl_flag_store(tl_flag_store), .tl_flag_isbyte(tl_flag_isbyte),
    .tl_flag_tlbwrite(tl_flag_tlbwrite),
    .rf_wen(rf_wen), .rf_thread(rf_thread), .rf_dst(rf_dst), .rf_data(rf_data),
    .redirect_en(redirect_en), .redirect_thread(redirect_thread), .redirect_pc(redirect_pc),
    .invalidate_en(invalidate_en), .invalidate_thread(invalidate_thread),
    .store_en(store_en), .store_isbyte(store_isbyte), .store_addr(store_addr),
    .store_data(store_data), .itlb_wen(itlb_wen), .dtlb_wen(dtlb_wen),
    .tlbwrite_vpn(tlbwrite_vpn), .tlbwrite_ppn(tlbwrite_ppn),
    .exc_en(exc_en), .exc_thread(exc_thread), .mode(mode), .done(done),
    .dbg_rm1(dbg_rm1), .dbg_rm2(dbg_rm2)
  );

  typedef struct packed {
    logic [2:0]  thread;
    logic        valid, itlb, dtlb;
    logic [31:0] pc;
    logic [4:0]  dst;
    logic [31:0] data, mul, r2;
    logic        iseq, fmul, freg, fjump, fbranch, firet, fstore, fbyte;
    logic [1:0]  tlbw;
  } in_t;

  typedef struct packed {
    logic        rf_wen;
    logic [2:0]  rf_thread;
    logic [4:0]  rf_dst;
    logic [31:0] rf_data;
    logic        redir;
    logic [2:0]  redir_thread;
    logic [31:0] redir_pc;
    logic        inv;
    logic [2:0]  inv_thread;
    logic        st;
    logic        st_byte;
    logic [19:0] st_addr;
    logic [31:0] st_data;
    logic        itlb_wen, dtlb_wen;
    logic [19:0] vpn;
    logic [7:0]  ppn;
    logic        exc;
    logic [2:0]  exc_thread;
    logic [7:0]  mode;
    logic        done;
    logic [31:0] rm1, rm2;
  } exp_t;

  typedef struct packed {
    in_t         in;
    logic        rfw;
    logic [31:0] rfd;
    logic        red;
    logic [31:0] rpc;
    logic        inv;
    logic        exc;
    logic        st;
    logic        dt;
    logic [7:0]  md;
  } vec_t;

  int ncmp = 0;
  int nfail = 0;

  logic [31:0] m_wpc [NT];
  logic [31:0] m_rm0 [NT];
  logic [31:0] m_rm1 [NT];
  logic [31:0] m_rm2 [NT];
  logic [NT-1:0] m_rm4;
  logic m_exc;
  int m_master;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_wpc[i] = 32'h1000;
      m_rm0[i] = 0;
      m_rm1[i] = 0;
      m_rm2[i] = 0;
    end
    m_rm4 = '1;
    m_exc = 0;
    m_master = 0;
  endtask

  task automatic predict(input in_t v, output exp_t e);
    int t;
    logic [31:0] nxt;
    t = int'(v.thread);
    e = '0;
    if (v.pc == m_wpc[t]) begin
      if (!v.valid || (m_exc && t != m_master) || ((v.itlb || v.dtlb) && m_exc)) begin
        e.redir = 1; e.redir_thread = v.thread; e.redir_pc = m_wpc[t];
        e.inv = 1; e.inv_thread = v.thread;
      end else if (v.itlb || v.dtlb) begin
        m_exc = 1; m_master = t;
        m_rm0[t] = v.pc;
        m_rm1[t] = v.dtlb ? v.data : v.pc;
        m_rm2[t] = (v.dtlb ? 2 : 0) + (v.itlb ? 1 : 0);
        m_rm4[t] = 1;
        m_wpc[t] = EXC_PC;
        e.redir = 1; e.redir_thread = v.thread; e.redir_pc = EXC_PC;
        e.inv = 1; e.inv_thread = v.thread;
        e.exc = 1; e.exc_thread = v.thread;
      end else begin
        nxt = m_wpc[t] + 4;
        if (v.firet) begin
          nxt = m_rm0[t];
          m_rm4[t] = 0;
          if (t == m_master) m_exc = 0;
        end else if (v.fjump && (!v.fbranch || v.iseq)) begin
          nxt = v.data;
        end
        if (v.firet || (v.fjump && (!v.fbranch || v.iseq))) begin
          e.redir = 1; e.redir_thread = v.thread; e.redir_pc = nxt;
          e.inv = 1; e.inv_thread = v.thread;
        end
        m_wpc[t] = nxt;
        if (v.freg && v.dst != 0) begin
          e.rf_wen = 1; e.rf_thread = v.thread; e.rf_dst = v.dst;
          e.rf_data = v.fmul ? v.mul : v.data;
        end
        if (v.fstore) begin
          e.st = 1; e.st_byte = v.fbyte; e.st_addr = v.data[19:0]; e.st_data = v.r2;
        end
        e.itlb_wen = (v.tlbw == 2'd1);
        e.dtlb_wen = (v.tlbw == 2'd2);
        e.vpn = v.data[19:0];
        e.ppn = v.r2[7:0];
      end
    end
    e.mode = m_rm4;
    e.done = 1;
    for (int i = 0; i < NT; i++) if (m_wpc[i] != END_PC) e.done = 0;
    e.rm1 = m_rm1[t];
    e.rm2 = m_rm2[t];
  endtask

  task automatic drive(input in_t v);
    tl_thread = v.thread; tl_isvalid = v.valid; tl_itlb_miss = v.itlb; tl_dtlb_miss = v.dtlb;
    tl_pc = v.pc; tl_dst = v.dst; tl_data = v.data; tl_mul = v.mul; tl_r2 = v.r2;
    tl_isequal = v.iseq; tl_flag_mul = v.fmul; tl_flag_reg = v.freg; tl_flag_jump = v.fjump;
    tl_flag_branch = v.fbranch; tl_flag_iret = v.firet; tl_flag_store = v.fstore;
    tl_flag_isbyte = v.fbyte; tl_flag_tlbwrite = tlbwrite_t'(v.tlbw);
  endtask

  // Called just after a rising edge; inputs are captured by the next edge.
  task automatic apply(input in_t v, input string tag);
    exp_t e;
    predict(v, e);
    drive(v);
    @(posedge clk);
    #1;
    chk({tag, " rf_wen"}, rf_wen, e.rf_wen);
    chk({tag, " redirect_en"}, redirect_en, e.redir);
    chk({tag, " invalidate_en"}, invalidate_en, e.inv);
    chk({tag, " store_en"}, store_en, e.st);
    chk({tag, " itlb_wen"}, itlb_wen, e.itlb_wen);
    chk({tag, " dtlb_wen"}, dtlb_wen, e.dtlb_wen);
    chk({tag, " exc_en"}, exc_en, e.exc);
    chk({tag, " mode"}, mode, e.mode);
    chk({tag, " done"}, done, e.done);
    if (e.rf_wen) begin
      chk({tag, " rf_thread"}, rf_thread, e.rf_thread);
      chk({tag, " rf_dst"}, rf_dst, e.rf_dst);
      chk({tag, " rf_data"}, rf_data, e.rf_data);
    end
    if (e.redir) begin
      chk({tag, " redirect_thread"}, redirect_thread, e.redir_thread);
      chk({tag, " redirect_pc"}, redirect_pc, e.redir_pc);
    end
    if (e.inv) chk({tag, " invalidate_thread"}, invalidate_thread, e.inv_thread);
    if (e.st) begin
      chk({tag, " store_isbyte"}, store_isbyte, e.st_byte);
      chk({tag, " store_addr"}, store_addr, e.st_addr);
      chk({tag, " store_data"}, store_data, e.st_data);
    end
    if (e.itlb_wen || e.dtlb_wen) begin
      chk({tag, " tlbwrite_vpn"}, tlbwrite_vpn, e.vpn);
      chk({tag, " tlbwrite_ppn"}, tlbwrite_ppn, e.ppn);
    end
    if (e.exc) begin
      chk({tag, " exc_thread"}, exc_thread, e.exc_thread);
      chk({tag, " rm1"}, dbg_rm1[e.exc_thread], e.rm1);
      chk({tag, " rm2"}, dbg_rm2[e.exc_thread], e.rm2);
    end
  endtask

  function automatic in_t mk(input int t, input logic [31:0] pc, input logic [31:0] data);
    in_t r;
    r = '0;
    r.thread = 3'(t);
    r.pc = pc;
    r.data = data;
    r.valid = 1'b1;
    return r;
  endfunction

  function automatic vec_t mkv(input in_t v, input logic rfw, input logic [31:0] rfd,
                               input logic red, input logic [31:0] rpc, input logic inv,
                               input logic exc, input logic st, input logic dt,
                               input logic [7:0] md);
    vec_t r;
    r.in = v; r.rfw = rfw; r.rfd = rfd; r.red = red; r.rpc = rpc; r.inv = inv;
    r.exc = exc; r.st = st; r.dt = dt; r.md = md;
    return r;
  endfunction

  initial begin
    vec_t tbl[$];
    in_t v;
    string tag;

    v = mk(0, 32'h1000, 32'h55); v.freg = 1; v.dst = 3;
    drive(v);
    repeat (3) @(posedge clk);
    #1;
    chk("reset rf_wen", rf_wen, 0);
    chk("reset redirect_en", redirect_en, 0);
    chk("reset invalidate_en", invalidate_en, 0);
    chk("reset store_en", store_en, 0);
    chk("reset tlb_wen", {itlb_wen, dtlb_wen}, 0);
    chk("reset exc_en", exc_en, 0);
    chk("reset rf_data", rf_data, 0);
    chk("reset redirect_pc", redirect_pc, 0);
    chk("reset mode", mode, 8'hFF);
    chk("reset done", done, 0);
    rst = 1'b0;
    model_reset();

    v = mk(0, 32'h1000, 32'h55); v.freg = 1; v.dst = 3;
    tbl.push_back(mkv(v, 1, 32'h55, 0, 0, 0, 0, 0, 0, 8'hFF));
    v = mk(2, 32'h1008, 32'h9); v.freg = 1; v.dst = 1;
    tbl.push_back(mkv(v, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF));
    v = mk(1, 32'h1000, 32'h1010); v.fjump = 1;
    tbl.push_back(mkv(v, 0, 0, 1, 32'h1010, 1, 0, 0, 0, 8'hFF));
    v = mk(1, 32'h1010, 32'hABCDE); v.dtlb = 1; v.freg = 1; v.dst = 4; v.fstore = 1;
    tbl.push_back(mkv(v, 0, 0, 1, 32'h2000, 1, 1, 0, 0, 8'hFF));
    v = mk(4, 32'h1000, 32'h11); v.freg = 1; v.dst = 2;
    tbl.push_back(mkv(v, 0, 0, 1, 32'h1000, 1, 0, 0, 0, 8'hFF));
    v = mk(1, 32'h2000, 0); v.firet = 1;
    tbl.push_back(mkv(v, 0, 0, 1, 32'h1010, 1, 0, 0, 0, 8'hFD));
    v = mk(4, 32'h1000, 32'h77); v.freg = 1; v.fmul = 1; v.dst = 5; v.mul = 32'h99;
    tbl.push_back(mkv(v, 1, 32'h99, 0, 0, 0, 0, 0, 0, 8'hFD));
    v = mk(3, 32'h1000, 32'h1400); v.fjump = 1; v.fbranch = 1; v.iseq = 0;
    tbl.push_back(mkv(v, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFD));
    v = mk(3, 32'h1004, 32'h1400); v.fjump = 1; v.fbranch = 1; v.iseq = 1;
    tbl.push_back(mkv(v, 0, 0, 1, 32'h1400, 1, 0, 0, 0, 8'hFD));
    v = mk(5, 32'h1000, 32'h12345678); v.fstore = 1; v.fbyte = 1; v.r2 = 32'hFF;
    tbl.push_back(mkv(v, 0, 0, 0, 0, 0, 0, 1, 0, 8'hFD));
    v = mk(5, 32'h1004, 32'h12345678); v.tlbw = 2'd2; v.r2 = 32'hFF;
    tbl.push_back(mkv(v, 0, 0, 0, 0, 0, 0, 0, 1, 8'hFD));
    v = mk(6, 32'h1000, 32'h1); v.freg = 1; v.dst = 0;
    tbl.push_back(mkv(v, 0, 0, 0, 0, 0, 0, 0, 0, 8'hFD));
    v = mk(6, 32'h1004, 32'h5); v.valid = 0; v.freg = 1; v.dst = 1;
    tbl.push_back(mkv(v, 0, 0, 1, 32'h1004, 1, 0, 0, 0, 8'hFD));
    v = mk(7, 32'h1000, 32'h3333); v.itlb = 1;
    tbl.push_back(mkv(v, 0, 0, 1, 32'h2000, 1, 1, 0, 0, 8'hFD));
    v = mk(7, 32'h2000, 32'h4444); v.dtlb = 1;
    tbl.push_back(mkv(v, 0, 0, 1, 32'h2000, 1, 0, 0, 0, 8'hFD));
    v = mk(0, 32'h1004, 32'h66); v.freg = 1; v.dst = 3;
    tbl.push_back(mkv(v, 0, 0, 1, 32'h1004, 1, 0, 0, 0, 8'hFD));
    v = mk(7, 32'h2000, 0); v.firet = 1;
    tbl.push_back(mkv(v, 0, 0, 1, 32'h1000, 1, 0, 0, 0, 8'h7D));
    v = mk(0, 32'h1004, 32'h66); v.freg = 1; v.dst = 3;
    tbl.push_back(mkv(v, 1, 32'h66, 0, 0, 0, 0, 0, 0, 8'h7D));

    for (int i = 0; i < tbl.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      apply(tbl[i].in, tag);
      chk({tag, " tbl rf_wen"}, rf_wen, tbl[i].rfw);
      if (tbl[i].rfw) chk({tag, " tbl rf_data"}, rf_data, tbl[i].rfd);
      chk({tag, " tbl redirect_en"}, redirect_en, tbl[i].red);
      if (tbl[i].red) chk({tag, " tbl redirect_pc"}, redirect_pc, tbl[i].rpc);
      chk({tag, " tbl invalidate_en"}, invalidate_en, tbl[i].inv);
      chk({tag, " tbl exc_en"}, exc_en, tbl[i].exc);
      chk({tag, " tbl store_en"}, store_en, tbl[i].st);
      if (tbl[i].st) chk({tag, " tbl store_addr"}, store_addr, 32'h45678);
      chk({tag, " tbl dtlb_wen"}, dtlb_wen, tbl[i].dt);
      if (tbl[i].dt) chk({tag, " tbl tlbwrite_ppn"}, tlbwrite_ppn, 32'hFF);
      chk({tag, " tbl mode"}, mode, tbl[i].md);
    end

    v = mk(6, m_wpc[6], 32'hFFFF_FFFC); v.fjump = 1;
    apply(v, "wrap jump");
    v = mk(6, 32'hFFFF_FFFC, 32'h3); v.freg = 1; v.dst = 1;
    apply(v, "wrap top");
    v = mk(6, 32'h0, 32'h8); v.freg = 1; v.dst = 2;
    apply(v, "wrap zero");
    chk("wrap head at 0", rf_wen, 1);

    for (int t = 0; t < NT; t++) begin
      v = mk(t, m_wpc[t], END_PC); v.fjump = 1;
      apply(v, $sformatf("end t%0d", t));
      if (t == NT - 2) chk("done before last", done, 0);
    end
    chk("done all at end", done, 1);
    v = mk(0, END_PC, 32'h0);
    apply(v, "leave end");
    chk("done after leave", done, 0);

    for (int n = 0; n < 400; n++) begin
      v = '0;
      if (m_exc && $urandom_range(0, 1) == 1) v.thread = 3'(m_master);
      else v.thread = 3'($urandom_range(0, NT - 1));
      v.pc = ($urandom_range(0, 3) != 0) ? m_wpc[v.thread] : 32'($urandom());
      v.valid = ($urandom_range(0, 7) != 0);
      v.itlb = ($urandom_range(0, 11) == 0);
      v.dtlb = ($urandom_range(0, 11) == 0);
      v.dst = 5'($urandom());
      v.data = 32'($urandom());
      v.mul = 32'($urandom());
      v.r2 = 32'($urandom());
      v.iseq = 1'($urandom());
      v.fmul = 1'($urandom());
      v.freg = 1'($urandom());
      v.fjump = ($urandom_range(0, 3) == 0);
      v.fbranch = 1'($urandom());
      v.firet = ($urandom_range(0, 3) == 0);
      v.fstore = 1'($urandom());
      v.fbyte = 1'($urandom());
      v.tlbw = 2'($urandom_range(0, 2));
      apply(v, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
